// File: rtl/mc_model_nport_if.sv
// Request/response buses for mc_model_nport.
// Every bus is packed per port: port p sits at [p*W +: W].
interface mc_model_nport_if #(
  parameter int N  = 1,
  parameter int TW = 32
);
  logic [N-1:0]    mc_rq_vld;
  logic [3*N-1:0]  mc_rq_cmd;
  logic [4*N-1:0]  mc_rq_scmd;
  logic [48*N-1:0] mc_rq_vadr;
  logic [2*N-1:0]  mc_rq_size;
  logic [TW*N-1:0] mc_rq_rtnctl;
  logic [64*N-1:0] mc_rq_data;
  logic [N-1:0]    mc_rq_flush;
  logic [N-1:0]    mc_rq_stall;
  logic [N-1:0]    mc_rs_vld;
  logic [3*N-1:0]  mc_rs_cmd;
  logic [4*N-1:0]  mc_rs_scmd;
  logic [TW*N-1:0] mc_rs_rtnctl;
  logic [64*N-1:0] mc_rs_data;
  logic [N-1:0]    mc_rs_stall;

  modport master (
    output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr,
    output mc_rq_size, mc_rq_rtnctl, mc_rq_data, mc_rq_flush,
    output mc_rs_stall,
    input  mc_rq_stall,
    input  mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data
  );

  modport slave (
    input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr,
    input  mc_rq_size, mc_rq_rtnctl, mc_rq_data, mc_rq_flush,
    input  mc_rs_stall,
    output mc_rq_stall,
    output mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data
  );
endinterface

// File: rtl/mc_model_nport.sv
// N-port fixed-latency memory-controller model over one shared 64-bit RAM.
// MC_MODEL_RAND_STALL_EN: adds per-port LFSR pseudo-random request stall.
module mc_model_nport #(
  parameter int NUM_MC_PORTS    = 1,
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int RAM_DEPTH       = 2048,
  parameter int LATENCY         = 4,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  mc_model_nport_if.slave bus,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);
  localparam int N  = NUM_MC_PORTS;
  localparam int TW = MC_RTNCTL_WIDTH;
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;

  typedef struct packed {
    logic [2:0]    cmd;
    logic [3:0]    scmd;
    logic [TW-1:0] tag;
    logic [63:0]   data;
  } rsp_t;

  logic [63:0]          ram [RAM_DEPTH];
  logic [N-1:0]         rd_acc;
  logic [N-1:0]         wr_acc;
  logic [N-1:0][AW-1:0] widx;
  logic                 unused;

  assign unused = ^{bus.mc_rq_size, bus.mc_rq_vadr};

  function automatic logic [31:0] ones(input logic [N-1:0] v);
    ones = '0;
    for (int i = 0; i < N; i++) ones = ones + 32'(v[i]);
  endfunction

  // Descending loop: the lowest port's write is the last NBA and wins.
  always_ff @(posedge clk) begin
    for (int i = N - 1; i >= 0; i--)
      if (wr_acc[i]) ram[widx[i]] <= bus.mc_rq_data[i*64 +: 64];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      rd_count <= rd_count + ones(rd_acc);
      wr_count <= wr_count + ones(wr_acc);
    end
  end

  for (genvar p = 0; p < N; p++) begin : g_port
    logic [2:0]         cmd;
    logic               acc;
    logic [AW-1:0]      idx;
    rsp_t               arsp;
    logic [LATENCY-1:0] pv;
    rsp_t               pd [LATENCY];
    rsp_t               fmem [FIFO_DEPTH];
    rsp_t               head;
    logic [FW-1:0]      wp;
    logic [FW-1:0]      rp;
    logic [CW-1:0]      fcnt;
    logic [CW-1:0]      outst;
    logic [CW-1:0]      outst_n;
    logic               push;
    logic               pop;
    logic               vld;
    logic               pend;
    logic               pend_n;
    logic               stall_q;
    logic               rnd;

    assign cmd = bus.mc_rq_cmd[p*3 +: 3];
    assign acc = bus.mc_rq_vld[p] & ~bus.mc_rq_stall[p]
               & (cmd == 3'd1 | cmd == 3'd2);
    assign rd_acc[p] = acc & (cmd == 3'd1);
    assign wr_acc[p] = acc & (cmd == 3'd2);
    assign idx = bus.mc_rq_vadr[p*48+3 +: AW];
    assign widx[p] = idx;

    // Read data is captured here, before this cycle's writes land.
    always_comb begin
      arsp = '0;
      arsp.cmd = (cmd == 3'd2) ? 3'd3 : 3'd2;
      arsp.scmd = bus.mc_rq_scmd[p*4 +: 4];
      arsp.tag = bus.mc_rq_rtnctl[p*TW +: TW];
      if (cmd == 3'd1) arsp.data = ram[idx];
    end

    assign push = pv[LATENCY-1];
    assign vld = fcnt != '0;
    assign pop = vld & ~bus.mc_rs_stall[p];
    assign head = fmem[rp];
    assign outst_n = outst + CW'(acc) - CW'(pop);
    assign pend_n = bus.mc_rq_flush[p] | (pend & (outst != '0));

    always_ff @(posedge clk) begin
      pd[0] <= arsp;
      for (int i = 1; i < LATENCY; i++) pd[i] <= pd[i-1];
      if (push) fmem[wp] <= pd[LATENCY-1];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pv      <= '0;
        wp      <= '0;
        rp      <= '0;
        fcnt    <= '0;
        outst   <= '0;
        pend    <= 1'b0;
        stall_q <= 1'b0;
      end else begin
        pv      <= LATENCY'({pv, acc});
        if (push) wp <= wp + FW'(1);
        if (pop) rp <= rp + FW'(1);
        fcnt    <= fcnt + CW'(push) - CW'(pop);
        outst   <= outst_n;
        pend    <= pend_n;
        stall_q <= (outst_n >= CW'(FIFO_DEPTH - 1)) | pend_n;
        assert (!(push && !pop && fcnt == CW'(FIFO_DEPTH)));
      end
    end

`ifdef MC_MODEL_RAND_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr <= 16'hACE1 ^ 16'(p);
      else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign rnd = lfsr[2:0] == 3'd0;
`else
    assign rnd = 1'b0;
`endif

    assign bus.mc_rq_stall[p] = stall_q | rnd;
    assign bus.mc_rs_vld[p] = vld;
    assign bus.mc_rs_cmd[p*3 +: 3] = vld ? head.cmd : 3'd0;
    assign bus.mc_rs_scmd[p*4 +: 4] = vld ? head.scmd : 4'd0;
    assign bus.mc_rs_rtnctl[p*TW +: TW] = vld ? head.tag : '0;
    assign bus.mc_rs_data[p*64 +: 64] = vld ? head.data : 64'd0;
  end
endmodule

// File: tb/tb_mc_model_nport.sv
// Scoreboard bench for mc_model_nport: driver pushes expected responses,
// monitor pops and compares on every response handshake.
module tb_mc_model_nport;
  localparam int N   = 2;
  localparam int TW  = 8;
  localparam int RD  = 256;
  localparam int LAT = 4;
  localparam int FD  = 8;

  typedef struct {
    logic [2:0]    cmd;
    logic [3:0]    scmd;
    logic [TW-1:0] tag;
    logic [63:0]   data;
    int            acc;
    bit            exact;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  mc_model_nport_if #(.N(N), .TW(TW)) bus ();

  mc_model_nport #(
    .NUM_MC_PORTS(N), .MC_RTNCTL_WIDTH(TW), .RAM_DEPTH(RD),
    .LATENCY(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  exp_t sbq [N][$];
  logic [63:0] mem [RD];
  int mrd = 0;
  int mwr = 0;
  bit exact_mode = 1'b1;
  int hs_cnt [N];

  logic [N-1:0]  r_vld = '0;
  logic [N-1:0]  r_flush = '0;
  logic [N-1:0]  r_rsst = '0;
  logic [2:0]    r_cmd [N];
  logic [3:0]    r_scmd [N];
  logic [47:0]   r_adr [N];
  logic [TW-1:0] r_tag [N];
  logic [63:0]   r_dat [N];

  task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  function automatic logic [79:0] rs_word(int p);
    return {bus.mc_rs_vld[p], bus.mc_rs_cmd[p*3 +: 3], bus.mc_rs_scmd[p*4 +: 4],
            bus.mc_rs_rtnctl[p*TW +: TW], bus.mc_rs_data[p*64 +: 64]};
  endfunction

  function automatic int pending();
    int s = 0;
    for (int p = 0; p < N; p++) s += sbq[p].size();
    return s;
  endfunction

  // One cycle of stimulus; the reference model is updated for every accept.
  task automatic step(output logic [N-1:0] acc);
    int   w [N];
    exp_t e;
    bit   shadow;
    for (int p = 0; p < N; p++) begin
      bus.mc_rq_vld[p] = r_vld[p];
      bus.mc_rq_cmd[p*3 +: 3] = r_cmd[p];
      bus.mc_rq_scmd[p*4 +: 4] = r_scmd[p];
      bus.mc_rq_vadr[p*48 +: 48] = r_adr[p];
      bus.mc_rq_size[p*2 +: 2] = 2'($urandom);
      bus.mc_rq_rtnctl[p*TW +: TW] = r_tag[p];
      bus.mc_rq_data[p*64 +: 64] = r_dat[p];
    end
    bus.mc_rq_flush = r_flush;
    bus.mc_rs_stall = r_rsst;
    @(negedge clk);
    acc = r_vld & ~bus.mc_rq_stall;
    for (int p = 0; p < N; p++) begin
      w[p] = int'((r_adr[p] >> 3) % 48'(RD));
      if (acc[p] && (r_cmd[p] == 3'd1 || r_cmd[p] == 3'd2)) begin
        e.cmd = (r_cmd[p] == 3'd1) ? 3'd2 : 3'd3;
        e.scmd = r_scmd[p];
        e.tag = r_tag[p];
        e.data = (r_cmd[p] == 3'd1) ? mem[w[p]] : 64'd0;
        e.acc = cyc + 1;
        e.exact = exact_mode;
        sbq[p].push_back(e);
        if (r_cmd[p] == 3'd1) mrd++;
        else mwr++;
      end
    end
    for (int p = 0; p < N; p++) begin
      if (acc[p] && r_cmd[p] == 3'd2) begin
        shadow = 1'b0;
        for (int q = 0; q < p; q++)
          if (acc[q] && r_cmd[q] == 3'd2 && w[q] == w[p]) shadow = 1'b1;
        if (!shadow) mem[w[p]] = r_dat[p];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    logic [N-1:0] acc;
    r_vld = '0;
    repeat (n) step(acc);
  endtask

  task automatic req(int p, logic [2:0] c, logic [47:0] a,
                     logic [TW-1:0] t, logic [63:0] d);
    logic [N-1:0] acc;
    int k = 0;
    r_vld = '0;
    r_vld[p] = 1'b1;
    r_cmd[p] = c;
    r_adr[p] = a;
    r_tag[p] = t;
    r_dat[p] = d;
    r_scmd[p] = 4'($urandom);
    do begin
      step(acc);
      k++;
    end while (!acc[p] && k < 60);
    r_vld = '0;
    chk("req_accept", acc[p], 1);
  endtask

  // Monitor: compares on handshakes and checks stability while stalled.
  initial begin : monitor
    logic [79:0] held [N];
    bit          hold [N];
    exp_t        e;
    for (int p = 0; p < N; p++) begin
      hold[p] = 1'b0;
      hs_cnt[p] = 0;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < N; p++) begin
        if (reset) begin
          hold[p] = 1'b0;
        end else begin
          if (hold[p]) chk("rs_hold_stable", rs_word(p), held[p]);
          hold[p] = bus.mc_rs_vld[p] & bus.mc_rs_stall[p];
          held[p] = rs_word(p);
          if (bus.mc_rs_vld[p] && !bus.mc_rs_stall[p]) begin
            hs_cnt[p]++;
            if (sbq[p].size() == 0) begin
              chk("unexpected_rsp", rs_word(p), 0);
            end else begin
              e = sbq[p].pop_front();
              chk("rsp_fields",
                  {bus.mc_rs_cmd[p*3 +: 3], bus.mc_rs_scmd[p*4 +: 4],
                   bus.mc_rs_rtnctl[p*TW +: TW], bus.mc_rs_data[p*64 +: 64]},
                  {e.cmd, e.scmd, e.tag, e.data});
              if (e.exact) chk("rsp_latency", cyc, e.acc + LAT);
              else chk("rsp_not_early", cyc >= e.acc + LAT, 1);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [N-1:0] acc;
    int nacc;
    int k;
    int base;
    int c;
    logic [31:0] wr0;
    for (int p = 0; p < N; p++) begin
      r_cmd[p] = '0; r_scmd[p] = '0; r_adr[p] = '0;
      r_tag[p] = '0; r_dat[p] = '0;
    end
    bus.mc_rq_vld = '0; bus.mc_rq_cmd = '0; bus.mc_rq_scmd = '0;
    bus.mc_rq_vadr = '0; bus.mc_rq_size = '0; bus.mc_rq_rtnctl = '0;
    bus.mc_rq_data = '0; bus.mc_rq_flush = '0; bus.mc_rs_stall = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rs_vld", bus.mc_rs_vld, 0);
    chk("reset_rq_stall", bus.mc_rq_stall, 0);
    chk("reset_rs_data", bus.mc_rs_data, 0);
    chk("reset_counts", {rd_count, wr_count}, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Give every word the random phase touches a known value.
    for (int i = 0; i < 16; i++)
      req(0, 3'd2, 48'(i * 8), TW'(i), {$urandom, $urandom});
    idle(8);

    req(0, 3'd2, 48'h40, 8'd5, 64'hDEAD_BEEF);
    req(0, 3'd1, 48'h40, 8'd6, 64'd0);
    idle(8);

    wr0 = wr_count;
    r_vld = 2'b11;
    r_cmd[0] = 3'd2; r_adr[0] = 48'h100; r_dat[0] = 64'd1; r_tag[0] = 8'h11;
    r_cmd[1] = 3'd2; r_adr[1] = 48'h100; r_dat[1] = 64'd2; r_tag[1] = 8'h12;
    step(acc);
    chk("dual_write_acc", acc, 2'b11);
    chk("dual_write_count", wr_count, wr0 + 2);
    r_cmd[0] = 3'd1; r_tag[0] = 8'h13;
    r_dat[1] = 64'd7; r_tag[1] = 8'h14;
    step(acc);
    chk("rd_wr_conflict_acc", acc, 2'b11);
    r_vld = '0;
    req(1, 3'd1, 48'h100, 8'h15, 64'd0);
    idle(8);

    req(1, 3'd2, 48'h18, 8'h21, 64'h1234_5678_9ABC_DEF0);
    req(1, 3'd1, 48'(RD * 8 + 'h18), 8'h22, 64'd0);
    idle(8);

    exact_mode = 1'b0;
    r_rsst[0] = 1'b1;
    nacc = 0;
    r_vld = '0; r_vld[0] = 1'b1;
    r_cmd[0] = 3'd1; r_adr[0] = 48'h40; r_tag[0] = 8'd10; r_scmd[0] = 4'd3;
    for (int i = 0; i < 20; i++) begin
      step(acc);
      if (acc[0]) begin
        nacc++;
        r_tag[0] = r_tag[0] + 1'b1;
      end
    end
    chk("stall_accepts", nacc, FD - 1);
    chk("rq_stall_full", bus.mc_rq_stall[0], 1);
    r_rsst[0] = 1'b0;
    k = 0;
    while (nacc < 10 && k < 60) begin
      step(acc);
      if (acc[0]) begin
        nacc++;
        r_tag[0] = r_tag[0] + 1'b1;
      end
      k++;
    end
    r_vld = '0;
    chk("stall_total_accepts", nacc, 10);
    idle(20);

    r_rsst[0] = 1'b1;
    for (int i = 0; i < 3; i++) req(0, 3'd1, 48'h40, TW'(20 + i), 64'd0);
    idle(6);
    r_flush[0] = 1'b1;
    step(acc);
    r_flush = '0;
    chk("flush_stall_set", bus.mc_rq_stall[0], 1);
    idle(3);
    chk("flush_stall_hold", bus.mc_rq_stall[0], 1);
    base = hs_cnt[0];
    r_rsst[0] = 1'b0;
    k = 0;
    do begin
      step(acc);
      k++;
    end while (hs_cnt[0] != base + 3 && k < 40);
    chk("flush_drained", hs_cnt[0], base + 3);
    chk("flush_stall_last_hs", bus.mc_rq_stall[0], 1);
    step(acc);
    chk("flush_stall_release", bus.mc_rq_stall[0], 0);
    idle(4);
    chk("mid_rd_count", rd_count, mrd);
    chk("mid_wr_count", wr_count, mwr);

    r_rsst = '1;
    for (int i = 0; i < 5; i++) req(0, 3'd1, 48'h40, TW'(40 + i), 64'd0);
    idle(2);
    chk("pre_reset_rs_vld", bus.mc_rs_vld[0], 1);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_rs_vld", bus.mc_rs_vld, 0);
    chk("async_reset_counts", {rd_count, wr_count}, 0);
    for (int p = 0; p < N; p++) sbq[p].delete();
    mrd = 0;
    mwr = 0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    r_rsst = '0;
    idle(20);
    chk("post_reset_rd_count", rd_count, 0);

    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < N; p++) begin
        r_vld[p] = ($urandom % 3) != 0;
        c = $urandom % 8;
        r_cmd[p] = (c < 3) ? 3'd1 : (c < 6) ? 3'd2 : (c == 6) ? 3'd0 : 3'd3;
        r_scmd[p] = 4'($urandom);
        r_tag[p] = TW'($urandom);
        r_dat[p] = {$urandom, $urandom};
        r_adr[p] = (48'($urandom_range(0, 255)) << 11)
                 | 48'($urandom_range(0, 15) * 8) | 48'($urandom % 8);
        r_rsst[p] = ($urandom % 4) == 0;
        r_flush[p] = ($urandom % 64) == 0;
      end
      step(acc);
    end
    r_vld = '0;
    r_flush = '0;
    r_rsst = '0;
    k = 0;
    while (pending() != 0 && k < 300) begin
      step(acc);
      k++;
    end
    chk("drain_empty", pending(), 0);
    chk("final_rd_count", rd_count, mrd);
    chk("final_wr_count", wr_count, mwr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
